// File: rtl/moore_vend_pkg.sv
// Shared types and constants for the Moore vending controller.
// Coin values are held in 5-rupee units throughout.
package moore_vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2
    } state_t;

    localparam logic [3:0] COIN5  = 4'd1;
    localparam logic [3:0] COIN10 = 4'd2;
    localparam logic [3:0] COIN25 = 4'd5;

    function automatic int credit_w(input int price);
        return $clog2(price / 5 + 1) + 1;
    endfunction

endpackage

// File: rtl/moore_vend_fsm_if.sv
// Coin/dispense bundle between the coin acceptor, controller and actuator.
// MOORE_VEND_CHANGE_EN adds the changeDue output (rupees).
interface moore_vend_fsm_if;
    logic       fiveRupees;
    logic       tenRupees;
    logic       twentyFiveRupees;
    logic       theProduct;
`ifdef MOORE_VEND_CHANGE_EN
    logic [5:0] changeDue;

    modport master (output fiveRupees, tenRupees, twentyFiveRupees,
                    input  theProduct, changeDue);
    modport slave  (input  fiveRupees, tenRupees, twentyFiveRupees,
                    output theProduct, changeDue);
`else
    modport master (output fiveRupees, tenRupees, twentyFiveRupees,
                    input  theProduct);
    modport slave  (input  fiveRupees, tenRupees, twentyFiveRupees,
                    output theProduct);
`endif
endinterface

// File: rtl/moore_vend_coin_sum.sv
// Combinational adder: simultaneous coin strobes -> total in 5-rupee units (max 8).
module moore_vend_coin_sum
    import moore_vend_pkg::*;
(
    input  logic       i_five,
    input  logic       i_ten,
    input  logic       i_twentyFive,
    output logic [3:0] o_units
);

    assign o_units = (i_five       ? COIN5  : 4'd0)
                   + (i_ten        ? COIN10 : 4'd0)
                   + (i_twentyFive ? COIN25 : 4'd0);

endmodule

// File: rtl/moore_vend_fsm.sv
// Moore vending controller: accumulates coins, strobes theProduct one cycle per sale.
// MOORE_VEND_CHANGE_EN enables the registered changeDue output.
module moore_vend_fsm
    import moore_vend_pkg::*;
#(
    parameter int PRICE = 25
) (
    input  logic             clock,
    input  logic             reset,
    moore_vend_fsm_if.slave  bus
);

    localparam int            CW      = credit_w(PRICE);
    localparam int            SW      = 7;
    localparam logic [SW-1:0] PRICE_U = SW'(PRICE / 5);

    state_t          currentState, w_nextState;
    logic [CW-1:0]   r_credit, w_nextCredit;
    logic [3:0]      w_units;
    logic [SW-1:0]   w_base, w_total;

    moore_vend_coin_sum u_coin_sum (
        .i_five       (bus.fiveRupees),
        .i_ten        (bus.tenRupees),
        .i_twentyFive (bus.twentyFiveRupees),
        .o_units      (w_units)
    );

    // A sale consumes the credit, so a DISPENSE cycle restarts from this cycle's coins.
    always_comb begin
        w_nextState  = currentState;
        w_nextCredit = r_credit;
        w_base       = (currentState == DISPENSE) ? '0 : SW'(r_credit);
        w_total      = w_base + SW'(w_units);
        if (w_total >= PRICE_U) begin
            w_nextState  = DISPENSE;
            w_nextCredit = '0;
        end else if (w_total == '0) begin
            w_nextState  = IDLE;
            w_nextCredit = '0;
        end else begin
            w_nextState  = CREDIT;
            w_nextCredit = CW'(w_total);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            currentState <= IDLE;
            r_credit     <= '0;
        end else begin
            currentState <= w_nextState;
            r_credit     <= w_nextCredit;
        end
    end

    assign bus.theProduct = (currentState == DISPENSE);

`ifdef MOORE_VEND_CHANGE_EN
    logic [5:0] r_change, w_nextChange;

    always_comb begin
        w_nextChange = '0;
        if (w_total >= PRICE_U)
            w_nextChange = 6'((w_total - PRICE_U) * SW'(5));
    end

    always_ff @(posedge clock) begin
        if (!reset) r_change <= '0;
        else        r_change <= w_nextChange;
    end

    assign bus.changeDue = r_change;
`endif

endmodule

// File: tb/tb_moore_vend_fsm.sv
// Bench for moore_vend_fsm: directed scenarios plus random coins against a rupee-level model.
// Define MOORE_VEND_CHANGE_EN to also check changeDue.
module tb_moore_vend_fsm;
    import moore_vend_pkg::*;

    localparam int PRICE = 25;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    // model: credit and change in rupees, plus whether a sale happened last edge
    int   m_credit = 0;
    int   m_change = 0;
    bit   m_sold   = 1'b0;

    moore_vend_fsm_if vif ();

    moore_vend_fsm #(.PRICE(PRICE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (vif)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit f, input bit t, input bit q);
        int total;
        if (!rst) begin
            m_credit = 0; m_change = 0; m_sold = 1'b0;
            return;
        end
        total = (m_sold ? 0 : m_credit) + 5 * int'(f) + 10 * int'(t) + 25 * int'(q);
        if (total >= PRICE) begin
            m_sold = 1'b1; m_change = total - PRICE; m_credit = 0;
        end else begin
            m_sold = 1'b0; m_change = 0; m_credit = total;
        end
    endtask

    task automatic cyc(input string tag, input bit rst, input bit f, input bit t, input bit q);
        state_t exp_st;
        reset                = rst;
        vif.fiveRupees       = f;
        vif.tenRupees        = t;
        vif.twentyFiveRupees = q;
        @(posedge clock);
        model_step(rst, f, t, q);
        @(negedge clock);
        exp_st = m_sold ? DISPENSE : (m_credit == 0 ? IDLE : CREDIT);
        chk({tag, ".product"}, int'(vif.theProduct), int'(m_sold));
        chk({tag, ".state"}, int'(dut.currentState), int'(exp_st));
        chk({tag, ".credit"}, int'(dut.r_credit) * 5, m_credit);
`ifdef MOORE_VEND_CHANGE_EN
        chk({tag, ".change"}, int'(vif.changeDue), m_change);
`endif
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        vif.fiveRupees = 1'b0; vif.tenRupees = 1'b0; vif.twentyFiveRupees = 1'b0;
        @(negedge clock);

        // reset with all coins high
        cyc("rst0", 1'b0, 1'b1, 1'b1, 1'b1);
        cyc("rst1", 1'b0, 1'b1, 1'b1, 1'b1);
        chk("rst.idle_state", int'(dut.currentState), int'(IDLE));

        // 5, idle, 10, idle, 10
        cyc("t2.c5", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t2.credit5", int'(dut.r_credit) * 5, 5);
        idle("t2.i", 1);
        cyc("t2.c10a", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t2.credit15", int'(dut.r_credit) * 5, 15);
        idle("t2.i", 1);
        cyc("t2.c10b", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t2.sale", int'(vif.theProduct), 1);
        idle("t2.after", 1);
        chk("t2.back_idle", int'(dut.currentState), int'(IDLE));

        // single 25
        cyc("t3.c25", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t3.sale", int'(vif.theProduct), 1);
        idle("t3.after", 2);

        // 5 then 10, then hold
        cyc("t4.c5", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("t4.c10", 1'b1, 1'b0, 1'b1, 1'b0);
        idle("t4.hold", 5);
        chk("t4.held15", int'(dut.r_credit) * 5, 15);
        chk("t4.noprod", int'(vif.theProduct), 0);
        cyc("t4.rst", 1'b0, 1'b0, 1'b0, 1'b0);

        // 10+25 together: overpay by 10
        cyc("t5.c35", 1'b1, 1'b0, 1'b1, 1'b1);
`ifdef MOORE_VEND_CHANGE_EN
        chk("t5.change10", int'(vif.changeDue), 10);
`endif
        // 25 during DISPENSE -> back-to-back sale
        cyc("t6.c25", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t6.second_sale", int'(vif.theProduct), 1);
        cyc("t6.c10", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t6.credit10", int'(dut.r_credit) * 5, 10);
        cyc("t6.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6.rst_idle", int'(dut.currentState), int'(IDLE));

        // random traffic, sparse coins, occasional reset
        for (int i = 0; i < 400; i++) begin
            bit r, f, t, q;
            r = ($urandom_range(0, 39) != 0);
            f = ($urandom_range(0, 3) == 0);
            t = ($urandom_range(0, 3) == 0);
            q = ($urandom_range(0, 6) == 0);
            cyc("rnd", r, f, t, q);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
